prio_enc_seg_disp: RTL and testbench

- Parametrised successor to the board-level switch priority-encoder/7-seg demo.
- Synchronises and debounces an N-bit switch vector, then priority-encodes the highest set bit into a registered index and valid flag.
- Supports a hold (freeze) mode and counts result changes.
- Drives LEDs and NDIG active-low 7-segment digits directly: index in hex on the low digits, change count in hex on the rest.

---
 rtl/prio_enc_seg_disp.sv | 154 +++++++++++++++
 tb/tb_prio_enc_seg_disp.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/prio_enc_seg_disp.sv
// Switch priority encoder with synchroniser, debouncer, hold mode and change counter,
// driving LEDs and active-low hex 7-segment digits.
module prio_enc_seg_disp #(
    parameter int unsigned N          = 8,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned NDIG       = 8,
    parameter int unsigned LEDW       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        sw,
    input  logic                hold,
    output logic [LEDW-1:0]     ledr,
    output logic [8*NDIG-1:0]   seg
);

    localparam int unsigned IW      = $clog2(N);
    localparam int unsigned IDX_DIG = (IW + 3) / 4;
    localparam int unsigned XW      = 4 * IDX_DIG;
    localparam int unsigned CW      = 4 * (NDIG - IDX_DIG);
    localparam int unsigned DW      = $clog2(DEB_CYCLES) + 1;

    localparam logic [7:0] SEG_DASH = 8'b1011_1111;

    // Parameter sanity, caught at elaboration
    generate
        if (N < 2) begin : g_bad_n
            $error("prio_enc_seg_disp: N must be >= 2");
        end
        if (DEB_CYCLES < 1) begin : g_bad_deb
            $error("prio_enc_seg_disp: DEB_CYCLES must be >= 1");
        end
        if (NDIG <= IDX_DIG) begin : g_bad_ndig
            $error("prio_enc_seg_disp: NDIG must exceed the index digit count");
        end
        if (LEDW < IW + 1) begin : g_bad_ledw
            $error("prio_enc_seg_disp: LEDW must be >= IW+1");
        end
    endgenerate

    logic [N-1:0]    s1;
    logic [N-1:0]    s2;
    logic [N-1:0]    cand;
    logic [N-1:0]    stable;
    logic [DW-1:0]   cnt_deb;
    logic [IW-1:0]   idx_q;
    logic            valid_q;
    logic [CW-1:0]   chg_cnt;

    logic [IW-1:0]   enc_idx;
    logic            enc_valid;
    logic            result_chg;
    logic [XW-1:0]   idx_ext;
    logic [8*NDIG-1:0] seg_c;

    // Active-low hex glyph, dp off
    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        logic [7:0] g;
        g = 8'hFF;
        case (nib)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            4'hF: g = 8'h8E;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    // Two-flop synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    // Debounce: any change of s2 restarts the window; counter saturates once accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            cand    <= '0;
            stable  <= '0;
            cnt_deb <= '0;
        end else if (s2 != cand) begin
            cand    <= s2;
            cnt_deb <= '0;
        end else if (cnt_deb == DW'(DEB_CYCLES - 1)) begin
            stable  <= cand;
        end else begin
            cnt_deb <= cnt_deb + DW'(1);
        end
    end

    // Highest set bit wins; later iterations override lower ones
    always_comb begin
        enc_idx   = '0;
        enc_valid = |stable;
        for (int i = 0; i < N; i++) begin
            if (stable[i]) begin
                enc_idx = IW'(i);
            end
        end
    end

    assign result_chg = ({enc_valid, enc_idx} != {valid_q, idx_q});

    // Result and change counter freeze together under hold
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
            chg_cnt <= '0;
        end else if (!hold) begin
            idx_q   <= enc_idx;
            valid_q <= enc_valid;
            if (result_chg) begin
                chg_cnt <= chg_cnt + CW'(1);
            end
        end
    end

    assign idx_ext = XW'(idx_q);
    assign ledr    = LEDW'({valid_q, idx_q});

    // Display decode: index on the low digits, count above, dp of digit 0 flags hold
    always_comb begin
        seg_c = '1;
        for (int d = 0; d < IDX_DIG; d++) begin
            seg_c[8*d +: 8] = valid_q ? hex_glyph(idx_ext[4*d +: 4]) : SEG_DASH;
        end
        for (int d = 0; d < NDIG - IDX_DIG; d++) begin
            seg_c[8*(d + IDX_DIG) +: 8] = hex_glyph(chg_cnt[4*d +: 4]);
        end
        seg_c[7] = ~hold;
    end

    assign seg = seg_c;

endmodule

// File: tb/tb_prio_enc_seg_disp.sv
// Directed table-driven bench for prio_enc_seg_disp: default build plus a 2-digit build
// sharing the same stimulus to exercise counter wrap.
module tb_prio_enc_seg_disp;

    logic        clk;
    logic        rst;
    logic [7:0]  sw;
    logic        hold;
    logic [15:0] ledr1;
    logic [63:0] seg1;
    logic [15:0] ledr2;
    logic [15:0] seg2;

    int checks;
    int errors;

    typedef struct {
        logic [7:0]  sw;
        logic        hold;
        int          cyc;
        logic [15:0] ledr;
        logic [7:0]  dig0;
        int          cnt;
    } vec_t;

    vec_t vecs [11];

    prio_enc_seg_disp #(.N(8), .DEB_CYCLES(4), .NDIG(8), .LEDW(16)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .hold (hold),
        .ledr (ledr1),
        .seg  (seg1)
    );

    prio_enc_seg_disp #(.N(8), .DEB_CYCLES(4), .NDIG(2), .LEDW(16)) dut2 (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .hold (hold),
        .ledr (ledr2),
        .seg  (seg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] glyph(input logic [3:0] n);
        logic [7:0] t [16];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[n];
    endfunction

    // Seven count digits of the default build, leading zeros shown
    function automatic logic [55:0] cnt_digits(input int c);
        logic [55:0] r;
        for (int k = 0; k < 7; k++) begin
            r[8*k +: 8] = glyph(4'(c >> (4 * k)));
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        sw   = v.sw;
        hold = v.hold;
        repeat (v.cyc) tick();
        chk({tag, " ledr"},      64'(ledr1),       64'(v.ledr));
        chk({tag, " dig0"},      64'(seg1[7:0]),   64'(v.dig0));
        chk({tag, " cnt digits"},64'(seg1[63:8]),  64'(cnt_digits(v.cnt)));
        chk({tag, " ledr n2"},   64'(ledr2),       64'(v.ledr));
        chk({tag, " dig0 n2"},   64'(seg2[7:0]),   64'(v.dig0));
        chk({tag, " dig1 n2"},   64'(seg2[15:8]),  64'(glyph(4'(v.cnt))));
    endtask

    initial begin
        int cnt;
        vec_t w;

        checks = 0;
        errors = 0;

        vecs[0]  = '{sw: 8'hA0, hold: 1'b0, cyc: 20, ledr: 16'h000F, dig0: 8'hF8, cnt: 2};
        vecs[1]  = '{sw: 8'h01, hold: 1'b0, cyc: 20, ledr: 16'h0008, dig0: 8'hC0, cnt: 3};
        vecs[2]  = '{sw: 8'h00, hold: 1'b0, cyc: 20, ledr: 16'h0000, dig0: 8'hBF, cnt: 4};
        vecs[3]  = '{sw: 8'h10, hold: 1'b0, cyc: 3,  ledr: 16'h0000, dig0: 8'hBF, cnt: 4};
        vecs[4]  = '{sw: 8'h00, hold: 1'b0, cyc: 20, ledr: 16'h0000, dig0: 8'hBF, cnt: 4};
        vecs[5]  = '{sw: 8'h10, hold: 1'b0, cyc: 6,  ledr: 16'h0000, dig0: 8'hBF, cnt: 4};
        vecs[6]  = '{sw: 8'h00, hold: 1'b0, cyc: 3,  ledr: 16'h000C, dig0: 8'h99, cnt: 5};
        vecs[7]  = '{sw: 8'h00, hold: 1'b0, cyc: 20, ledr: 16'h0000, dig0: 8'hBF, cnt: 6};
        vecs[8]  = '{sw: 8'h10, hold: 1'b0, cyc: 20, ledr: 16'h000C, dig0: 8'h99, cnt: 7};
        vecs[9]  = '{sw: 8'h02, hold: 1'b1, cyc: 20, ledr: 16'h000C, dig0: 8'h19, cnt: 7};
        vecs[10] = '{sw: 8'h02, hold: 1'b0, cyc: 1,  ledr: 16'h0009, dig0: 8'hF9, cnt: 8};

        // Reset defaults
        rst  = 1'b1;
        sw   = 8'h00;
        hold = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset ledr",    64'(ledr1), 64'h0);
        chk("reset seg",     seg1,       {{7{8'hC0}}, 8'hBF});
        chk("reset seg n2",  64'(seg2),  64'h0000_0000_0000_C0BF);

        // Exact latency: nothing after 7 edges, result on the 8th
        sw = 8'h04;
        repeat (7) tick();
        chk("latency early ledr", 64'(ledr1), 64'h0);
        tick();
        chk("latency ledr", 64'(ledr1),      64'h000A);
        chk("latency dig0", 64'(seg1[7:0]),  64'hA4);
        chk("latency dig1", 64'(seg1[15:8]), 64'hF9);

        for (int i = 0; i < 11; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Toggle until the 4-bit counter of the 2-digit build wraps
        cnt = 8;
        for (int i = 0; i < 8; i++) begin
            cnt++;
            w.sw   = (i % 2 == 0) ? 8'h80 : 8'h00;
            w.hold = 1'b0;
            w.cyc  = 20;
            w.ledr = (i % 2 == 0) ? 16'h000F : 16'h0000;
            w.dig0 = (i % 2 == 0) ? 8'hF8 : 8'hBF;
            w.cnt  = cnt;
            run_vec($sformatf("wrap%0d", i), w);
        end
        chk("wrap dig1 n2",   64'(seg2[15:8]),  64'hC0);
        chk("wrap dig1 n8",   64'(seg1[15:8]),  64'hC0);
        chk("wrap dig2 n8",   64'(seg1[23:16]), 64'hF9);

        // Reset while a new value is mid-debounce
        sw = 8'h40;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst ledr",   64'(ledr1), 64'h0);
        chk("midrst seg",    seg1,       {{7{8'hC0}}, 8'hBF});
        chk("midrst seg n2", 64'(seg2),  64'h0000_0000_0000_C0BF);
        repeat (7) tick();
        chk("midrst early ledr", 64'(ledr1), 64'h0);
        tick();
        chk("midrst ledr acc", 64'(ledr1),      64'h000E);
        chk("midrst dig0 acc", 64'(seg1[7:0]),  64'h82);
        chk("midrst cnt acc",  64'(seg1[63:8]), 64'(cnt_digits(1)));
        chk("midrst dig1 n2",  64'(seg2[15:8]), 64'hF9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
